// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: two-stage pipelined signed add/subtract unit.
// Stage 1 produces the low half of the sum and its carry. Stage 2 finishes
// the upper half and then derives carry-out, signed overflow and the
// saturated result. Both stages sit behind a valid/ready handshake, which
// allows one operation per cycle with no bubbles. A sticky overflow flag
// records any delivered result that overflowed.
module sat_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_sub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             ovfl_sticky,
  input  logic             clr_sticky
);

  localparam int H = WIDTH / 2;

  // ---------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------
  logic s1_valid_reg, s1_valid_next;
  logic out_valid_reg, out_valid_next;
  logic s2_ready;
  logic s1_load;
  logic s2_load;

  // The output register can take a new beat when it is empty or is being drained.
  assign s2_ready = ~out_valid_reg | out_ready;
  // Reset holds in_ready low, so no beat is accepted while the pipe is being flushed.
  assign in_ready = ~rst & (~s1_valid_reg | s2_ready);
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_reg & s2_ready;

  // ---------------------------------------------------------------
  // Stage 1: operand conditioning and the low-half add
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] b_in;
  logic [H:0]       lo_full;

  // When subtracting, invert B bit by bit. The +1 arrives through cin.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_in[gi] = b[gi] ^ is_sub;
    end
  endgenerate

  assign lo_full = {1'b0, a[H-1:0]} + {1'b0, b_in[H-1:0]} + {{H{1'b0}}, is_sub};

  logic [H-1:0] s1_lo_sum_reg,   s1_lo_sum_next;
  logic         s1_lo_carry_reg, s1_lo_carry_next;
  logic [H-1:0] s1_a_hi_reg,     s1_a_hi_next;
  logic [H-1:0] s1_b_hi_reg,     s1_b_hi_next;
  logic         s1_sat_en_reg,   s1_sat_en_next;

  // Stage 1 next-state logic: load on acceptance, otherwise hold (this covers stalls).
  always_comb begin
    s1_lo_sum_next   = s1_lo_sum_reg;
    s1_lo_carry_next = s1_lo_carry_reg;
    s1_a_hi_next     = s1_a_hi_reg;
    s1_b_hi_next     = s1_b_hi_reg;
    s1_sat_en_next   = s1_sat_en_reg;
    s1_valid_next    = s1_valid_reg;
    if (in_ready) begin
      s1_valid_next = in_valid;
    end
    if (s1_load) begin
      s1_lo_sum_next   = lo_full[H-1:0];
      s1_lo_carry_next = lo_full[H];
      s1_a_hi_next     = a[WIDTH-1:H];
      s1_b_hi_next     = b_in[WIDTH-1:H];
      s1_sat_en_next   = sat_en;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_lo_sum_reg   <= '0;
      s1_lo_carry_reg <= 1'b0;
      s1_a_hi_reg     <= '0;
      s1_b_hi_reg     <= '0;
      s1_sat_en_reg   <= 1'b0;
    end else begin
      s1_valid_reg    <= s1_valid_next;
      s1_lo_sum_reg   <= s1_lo_sum_next;
      s1_lo_carry_reg <= s1_lo_carry_next;
      s1_a_hi_reg     <= s1_a_hi_next;
      s1_b_hi_reg     <= s1_b_hi_next;
      s1_sat_en_reg   <= s1_sat_en_next;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: upper-half add, overflow detection and saturation
  // ---------------------------------------------------------------
  logic [H:0]       hi_full;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sat_val;
  logic             a_msb;
  logic             b_msb;
  logic             ovfl_calc;
  logic             cout_calc;
  logic [WIDTH-1:0] sum_calc;

  assign hi_full   = {1'b0, s1_a_hi_reg} + {1'b0, s1_b_hi_reg} + {{H{1'b0}}, s1_lo_carry_reg};
  assign raw       = {hi_full[H-1:0], s1_lo_sum_reg};
  assign cout_calc = hi_full[H];
  assign a_msb     = s1_a_hi_reg[H-1];
  assign b_msb     = s1_b_hi_reg[H-1];
  // Overflow occurs when both operands have the same sign and the result sign differs from them.
  assign ovfl_calc = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);

  // Clamp toward the sign of A: a negative A saturates to MIN, a non-negative A to MAX.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_satv
      assign sat_val[gi] = ~a_msb;
    end
  endgenerate
  assign sat_val[WIDTH-1] = a_msb;

  assign sum_calc = (s1_sat_en_reg & ovfl_calc) ? sat_val : raw;

  logic [WIDTH-1:0] sum_reg,  sum_next;
  logic             cout_reg, cout_next;
  logic             ovfl_reg, ovfl_next;
  logic             sticky_reg, sticky_next;

  // Output stage next-state logic: advance when the output register frees up, otherwise hold.
  always_comb begin
    sum_next       = sum_reg;
    cout_next      = cout_reg;
    ovfl_next      = ovfl_reg;
    out_valid_next = out_valid_reg;
    if (s2_ready) begin
      out_valid_next = s1_valid_reg;
    end
    if (s2_load) begin
      sum_next  = sum_calc;
      cout_next = cout_calc;
      ovfl_next = ovfl_calc;
    end
  end

  // Sticky overflow flag: a delivered overflowing beat sets it, and it takes priority over a clear.
  always_comb begin
    sticky_next = sticky_reg;
    if (out_valid_reg & out_ready & ovfl_reg) begin
      sticky_next = 1'b1;
    end else if (clr_sticky) begin
      sticky_next = 1'b0;
    end
  end

  // Output registers and the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovfl_reg      <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      sum_reg       <= sum_next;
      cout_reg      <= cout_next;
      ovfl_reg      <= ovfl_next;
      sticky_reg    <= sticky_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign sum         = sum_reg;
  assign cout        = cout_reg;
  assign ovfl        = ovfl_reg;
  assign ovfl_sticky = sticky_reg;

endmodule
